// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared types and widths for the RAM arbiter.
//   owner_t    - which requester owns a RAM cycle (none / VGA / CPU / DMA)
//   ADDR_W     - RAM and CPU/DMA address width
//   DATA_W     - RAM data width
//   VGA_ADDR_W - VGA fetch address width (upper bits come from VGA_BASE)
package ram_arb_pkg;
   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 8;
   localparam int VGA_ADDR_W = 13;
   localparam int VGA_BASE_W = ADDR_W - VGA_ADDR_W;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VGA  = 2'd1,
      OWN_CPU  = 2'd2,
      OWN_DMA  = 2'd3
   } owner_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of all requester and RAM-side signals of the arbiter.
//   phase                          slot indicator (0 = VGA slot, 1 = CPU slot)
//   cpu_req/we/addr/dbw, cpu_dbr/rdy    CPU port
//   vga_req/addr, vga_dbr/valid         VGA fetch port (read only)
//   dma_req/we/addr/dbw, dma_gnt/dbr/done DMA port
//   ram_addr/dbw/we, ram_dbr            single-port synchronous RAM
// Modport slave is the arbiter's view; master is the requesters'/RAM's view.
interface ram_arbiter_if;
   import ram_arb_pkg::*;

   logic                  phase;

   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_W-1:0]     cpu_addr;
   logic [DATA_W-1:0]     cpu_dbw;
   logic [DATA_W-1:0]     cpu_dbr;
   logic                  cpu_rdy;

   logic                  vga_req;
   logic [VGA_ADDR_W-1:0] vga_addr;
   logic [DATA_W-1:0]     vga_dbr;
   logic                  vga_valid;

   logic                  dma_req;
   logic                  dma_we;
   logic [ADDR_W-1:0]     dma_addr;
   logic [DATA_W-1:0]     dma_dbw;
   logic                  dma_gnt;
   logic [DATA_W-1:0]     dma_dbr;
   logic                  dma_done;

   logic [ADDR_W-1:0]     ram_addr;
   logic [DATA_W-1:0]     ram_dbw;
   logic                  ram_we;
   logic [DATA_W-1:0]     ram_dbr;

   modport slave (
      output phase,
      input  cpu_req, cpu_we, cpu_addr, cpu_dbw,
      output cpu_dbr, cpu_rdy,
      input  vga_req, vga_addr,
      output vga_dbr, vga_valid,
      input  dma_req, dma_we, dma_addr, dma_dbw,
      output dma_gnt, dma_dbr, dma_done,
      output ram_addr, ram_dbw, ram_we,
      input  ram_dbr
   );

   modport master (
      input  phase,
      output cpu_req, cpu_we, cpu_addr, cpu_dbw,
      input  cpu_dbr, cpu_rdy,
      output vga_req, vga_addr,
      input  vga_dbr, vga_valid,
      output dma_req, dma_we, dma_addr, dma_dbw,
      input  dma_gnt, dma_dbr, dma_done,
      input  ram_addr, ram_dbw, ram_we,
      output ram_dbr
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: time-slices one single-port synchronous RAM between VGA, CPU
// and DMA. Even cycles are VGA slots, odd cycles CPU slots; DMA fills unused
// slots and steals a CPU slot once it has waited STARVE_LIM cycles.
// Ports:
//   clk - system clock
//   rst - synchronous, active-low reset
//   bus - ram_arbiter_if.slave (requester ports and RAM port)
// Timing: owner chosen combinationally in cycle N, RAM data returns in N+1
// and is captured at the end of N+1, strobes are visible in N+2.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter logic [VGA_BASE_W-1:0] VGA_BASE   = 3'b110,
   parameter int                    STARVE_LIM = 8
) (
   input  logic          clk,
   input  logic          rst,
   ram_arbiter_if.slave  bus
);

   localparam int WAIT_W = $clog2(STARVE_LIM + 1);

   logic              phase_reg;
   logic [WAIT_W-1:0] wait_reg;
   owner_t            s1_owner_reg;
   logic              s1_we_reg;
   logic [DATA_W-1:0] cpu_dbr_reg;
   logic [DATA_W-1:0] vga_dbr_reg;
   logic [DATA_W-1:0] dma_dbr_reg;
   logic              vga_valid_reg;
   logic              dma_done_reg;

   owner_t            owner;
   logic              owner_we;
   logic              starving;

   assign starving = (wait_reg >= WAIT_W'(STARVE_LIM));

   // Slot owner for the current cycle. Held at none while in reset so the
   // RAM sees no write and DMA sees no grant.
   always_comb begin
      owner = OWN_NONE;
      if (rst) begin
         if (!phase_reg) begin
            if (bus.vga_req)      owner = OWN_VGA;
            else if (bus.dma_req) owner = OWN_DMA;
         end else begin
            if (bus.dma_req && starving) owner = OWN_DMA;
            else if (bus.cpu_req)        owner = OWN_CPU;
            else if (bus.dma_req)        owner = OWN_DMA;
         end
      end
   end

   // RAM port mux; idle cycles present the CPU address with no write.
   always_comb begin
      owner_we     = 1'b0;
      bus.ram_addr = bus.cpu_addr;
      bus.ram_dbw  = bus.cpu_dbw;
      case (owner)
         OWN_VGA: begin
            bus.ram_addr = {VGA_BASE, bus.vga_addr};
         end
         OWN_CPU: begin
            owner_we = bus.cpu_we;
         end
         OWN_DMA: begin
            owner_we     = bus.dma_we;
            bus.ram_addr = bus.dma_addr;
            bus.ram_dbw  = bus.dma_dbw;
         end
         default: begin
            owner_we = 1'b0;
         end
      endcase
   end

   assign bus.ram_we  = owner_we;
   assign bus.dma_gnt = (owner == OWN_DMA);
   // The CPU loses its slot only when a starving DMA takes it.
   assign bus.cpu_rdy = !(rst && phase_reg && starving && bus.dma_req);

   assign bus.phase     = phase_reg;
   assign bus.cpu_dbr   = cpu_dbr_reg;
   assign bus.vga_dbr   = vga_dbr_reg;
   assign bus.dma_dbr   = dma_dbr_reg;
   assign bus.vga_valid = vga_valid_reg;
   assign bus.dma_done  = dma_done_reg;

   // Stage 1 remembers who owned cycle N; stage 2 (data registers and
   // strobes) consumes ram_dbr at the end of N+1. Two accesses can be in
   // flight, which is what allows back-to-back DMA grants.
   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_reg     <= 1'b0;
         wait_reg      <= '0;
         s1_owner_reg  <= OWN_NONE;
         s1_we_reg     <= 1'b0;
         cpu_dbr_reg   <= 8'hFF;
         vga_dbr_reg   <= 8'hFF;
         dma_dbr_reg   <= 8'hFF;
         vga_valid_reg <= 1'b0;
         dma_done_reg  <= 1'b0;
      end else begin
         phase_reg <= ~phase_reg;

         // Count consecutive ungranted DMA cycles, saturating at the limit.
         if (bus.dma_req && !bus.dma_gnt) begin
            if (!starving) wait_reg <= wait_reg + WAIT_W'(1);
         end else begin
            wait_reg <= '0;
         end

         s1_owner_reg <= owner;
         s1_we_reg    <= owner_we;

         vga_valid_reg <= (s1_owner_reg == OWN_VGA);
         dma_done_reg  <= (s1_owner_reg == OWN_DMA);

         if (s1_owner_reg == OWN_VGA)               vga_dbr_reg <= bus.ram_dbr;
         if (s1_owner_reg == OWN_CPU && !s1_we_reg) cpu_dbr_reg <= bus.ram_dbr;
         if (s1_owner_reg == OWN_DMA && !s1_we_reg) dma_dbr_reg <= bus.ram_dbr;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: drives ram_arbiter with directed and random traffic and
// checks every cycle against a transaction-level model (slot rules, a
// reference memory and a queue of outstanding accesses).
module tb_ram_arbiter;

   localparam int LIM    = 8;
   localparam int O_NONE = 0;
   localparam int O_VGA  = 1;
   localparam int O_CPU  = 2;
   localparam int O_DMA  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;

   ram_arbiter_if bus ();

   ram_arbiter #(.VGA_BASE(3'b110), .STARVE_LIM(LIM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM behind the arbiter.
   bit [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_dbw;
      bus.ram_dbr <= mem[bus.ram_addr];
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int       owner;
      bit       we;
      bit [7:0] data;
      int       age;
   } acc_t;

   acc_t     pend[$];
   bit [7:0] ref_mem [0:65535];
   bit       model_ok = 1'b0;
   bit       m_phase = 1'b0;
   int       m_wait = 0;
   bit       m_vv = 1'b0;
   bit       m_dd = 1'b0;
   bit [7:0] m_cpu_dbr = 8'hFF;
   bit [7:0] m_vga_dbr = 8'hFF;
   bit [7:0] m_dma_dbr = 8'hFF;

   int          e_own;
   bit          e_starve;
   bit          e_rdy;
   bit          e_we;
   logic [15:0] e_addr;
   logic [7:0]  e_dbw;
   acc_t        acc;

   always @(negedge clk) begin
      e_starve = (m_wait >= LIM);
      e_own    = O_NONE;
      if (rst) begin
         if (!m_phase) begin
            if (bus.vga_req)      e_own = O_VGA;
            else if (bus.dma_req) e_own = O_DMA;
         end else if (bus.dma_req && e_starve) e_own = O_DMA;
         else if (bus.cpu_req)  e_own = O_CPU;
         else if (bus.dma_req)  e_own = O_DMA;
      end
      e_rdy  = !(rst && m_phase && e_starve && bus.dma_req);
      e_we   = (e_own == O_CPU) ? bus.cpu_we : (e_own == O_DMA) ? bus.dma_we : 1'b0;
      e_addr = (e_own == O_VGA) ? (16'hC000 | {3'b000, bus.vga_addr})
             : (e_own == O_DMA) ? bus.dma_addr : bus.cpu_addr;
      e_dbw  = (e_own == O_DMA) ? bus.dma_dbw : bus.cpu_dbw;

      if (model_ok) begin
         check("phase",     32'(bus.phase),     32'(m_phase));
         check("cpu_rdy",   32'(bus.cpu_rdy),   32'(e_rdy));
         check("dma_gnt",   32'(bus.dma_gnt),   32'(e_own == O_DMA));
         check("ram_we",    32'(bus.ram_we),    32'(e_we));
         check("ram_addr",  32'(bus.ram_addr),  32'(e_addr));
         if (e_we) check("ram_dbw", 32'(bus.ram_dbw), 32'(e_dbw));
         check("vga_valid", 32'(bus.vga_valid), 32'(m_vv));
         check("dma_done",  32'(bus.dma_done),  32'(m_dd));
         check("cpu_dbr",   32'(bus.cpu_dbr),   32'(m_cpu_dbr));
         check("vga_dbr",   32'(bus.vga_dbr),   32'(m_vga_dbr));
         check("dma_dbr",   32'(bus.dma_dbr),   32'(m_dma_dbr));
      end

      // Advance the model across the coming clock edge.
      if (!rst) begin
         model_ok  = 1'b1;
         m_phase   = 1'b0;
         m_wait    = 0;
         m_vv      = 1'b0;
         m_dd      = 1'b0;
         m_cpu_dbr = 8'hFF;
         m_vga_dbr = 8'hFF;
         m_dma_dbr = 8'hFF;
         pend.delete();
      end else begin
         m_vv = 1'b0;
         m_dd = 1'b0;
         foreach (pend[i]) pend[i].age++;
         while (pend.size() > 0 && pend[0].age >= 1) begin
            acc = pend.pop_front();
            if (acc.owner == O_VGA) begin
               m_vv = 1'b1;
               m_vga_dbr = acc.data;
            end else if (acc.owner == O_CPU) begin
               if (!acc.we) m_cpu_dbr = acc.data;
            end else if (acc.owner == O_DMA) begin
               m_dd = 1'b1;
               if (!acc.we) m_dma_dbr = acc.data;
            end
         end
         if (e_own != O_NONE) begin
            acc.owner = e_own;
            acc.we    = e_we;
            acc.data  = ref_mem[e_addr];
            acc.age   = 0;
            pend.push_back(acc);
            if (e_we) ref_mem[e_addr] = e_dbw;
         end
         if (bus.dma_req && e_own != O_DMA) m_wait = (m_wait + 1 > LIM) ? LIM : m_wait + 1;
         else m_wait = 0;
         m_phase = !m_phase;
      end
   end

   // ---------------- stimulus ----------------
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      bus.vga_req = 1'b0;
      bus.dma_req = 1'b0;
      bus.dma_we  = 1'b0;
   endtask

   // Returns at the negedge of a CPU slot; the next cycle is a VGA slot.
   task automatic align();
      int n;
      n = 0;
      tick();
      while (bus.phase !== 1'b1 && n < 4) begin
         adv();
         tick();
         n++;
      end
      check("align_phase", 32'(bus.phase), 1);
   endtask

   bit       gnt_seen;
   int       ndone;
   int       gnt_at;
   logic [7:0] got [4];
   logic [15:0] base;

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cpu_addr = 16'h0;
      bus.cpu_dbw  = 8'h0;
      bus.vga_addr = 13'h0;
      bus.dma_addr = 16'h0;
      bus.dma_dbw  = 8'h0;
      idle_inputs();
      // Requests active during reset must not reach the RAM.
      bus.cpu_req = 1'b1;
      bus.cpu_we  = 1'b1;
      bus.dma_req = 1'b1;
      bus.dma_we  = 1'b1;
      rst = 1'b0;
      repeat (3) adv();
      tick();
      check("rst_phase",   32'(bus.phase),     0);
      check("rst_cpu_dbr", 32'(bus.cpu_dbr),   32'hFF);
      check("rst_vga_dbr", 32'(bus.vga_dbr),   32'hFF);
      check("rst_dma_dbr", 32'(bus.dma_dbr),   32'hFF);
      check("rst_vvalid",  32'(bus.vga_valid), 0);
      check("rst_ddone",   32'(bus.dma_done),  0);
      check("rst_ram_we",  32'(bus.ram_we),    0);
      check("rst_dma_gnt", 32'(bus.dma_gnt),   0);
      check("rst_cpu_rdy", 32'(bus.cpu_rdy),   1);
      adv();
      rst = 1'b1;
      idle_inputs();

      // VGA/CPU alternation and VGA address mapping.
      align();
      adv();
      bus.vga_req = 1'b1; bus.vga_addr = 13'h0010;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
      tick();
      check("alt_vga_addr", 32'(bus.ram_addr), 32'hC010);
      check("alt_phase0",   32'(bus.phase), 0);
      adv(); tick();
      check("alt_cpu_addr", 32'(bus.ram_addr), 32'h1234);
      check("alt_phase1",   32'(bus.phase), 1);
      adv(); tick();
      check("alt_vvalid_n2", 32'(bus.vga_valid), 1);
      adv(); tick();
      check("alt_vvalid_n3", 32'(bus.vga_valid), 0);
      adv();
      idle_inputs();

      // CPU write then read back.
      align();
      adv();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_dbw = 8'h5A;
      tick(); check("cw_rdy0", 32'(bus.cpu_rdy), 1);
      adv(); tick();
      check("cw_we",  32'(bus.ram_we), 1);
      check("cw_rdy1", 32'(bus.cpu_rdy), 1);
      adv(); bus.cpu_we = 1'b0;
      tick(); check("cw_rdy2", 32'(bus.cpu_rdy), 1);
      adv(); tick();
      check("cr_we",   32'(bus.ram_we), 0);
      check("cr_addr", 32'(bus.ram_addr), 32'h0200);
      check("cr_rdy3", 32'(bus.cpu_rdy), 1);
      adv(); tick();
      adv(); bus.cpu_req = 1'b0;
      tick();
      check("cr_dbr", 32'(bus.cpu_dbr), 32'h5A);

      // DMA burst: four writes then four back-to-back reads.
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         adv();
         bus.dma_req = 1'b1; bus.dma_we = 1'b1;
         bus.dma_addr = 16'h0300 + 16'(i); bus.dma_dbw = 8'hA0 + 8'(i);
         tick();
         check("dw_gnt", 32'(bus.dma_gnt), 1);
      end
      adv(); bus.dma_req = 1'b0;
      repeat (3) begin tick(); adv(); end
      ndone = 0;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) begin
            bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0300 + 16'(i);
         end else begin
            bus.dma_req = 1'b0;
         end
         tick();
         if (i < 4) check("dr_gnt", 32'(bus.dma_gnt), 1);
         if (bus.dma_done && ndone < 4) begin
            got[ndone] = bus.dma_dbr;
            ndone++;
         end
         adv();
      end
      check("dr_done_count", 32'(ndone), 4);
      for (int i = 0; i < 4; i++) check("dr_data", 32'(got[i]), 32'hA0 + 32'(i));

      // DMA starvation against continuous VGA and CPU traffic.
      idle_inputs();
      align();
      adv();
      bus.vga_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0301;
      gnt_at = -1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.dma_gnt) begin
            gnt_at = k;
            break;
         end
         check("starve_rdy_wait", 32'(bus.cpu_rdy), 1);
         adv();
      end
      check("starve_grant_cycle", 32'(gnt_at), 9);
      check("starve_rdy_grant",   32'(bus.cpu_rdy), 0);
      check("starve_phase",       32'(bus.phase), 1);
      adv(); bus.dma_req = 1'b0;
      tick();
      check("starve_rdy_after", 32'(bus.cpu_rdy), 1);

      // Reset with VGA and DMA reads in flight.
      adv();
      idle_inputs();
      bus.vga_req = 1'b1; bus.dma_req = 1'b1; bus.dma_we = 1'b0;
      tick(); adv(); tick();
      adv();
      rst = 1'b0;
      tick();
      check("mr_ram_we",  32'(bus.ram_we), 0);
      check("mr_dma_gnt", 32'(bus.dma_gnt), 0);
      check("mr_cpu_rdy", 32'(bus.cpu_rdy), 1);
      adv();
      rst = 1'b1;
      idle_inputs();
      tick();
      check("mr_phase",   32'(bus.phase), 0);
      check("mr_cpu_dbr", 32'(bus.cpu_dbr), 32'hFF);
      check("mr_vga_dbr", 32'(bus.vga_dbr), 32'hFF);
      check("mr_dma_dbr", 32'(bus.dma_dbr), 32'hFF);
      for (int i = 0; i < 3; i++) begin
         check("mr_vvalid", 32'(bus.vga_valid), 0);
         check("mr_ddone",  32'(bus.dma_done), 0);
         adv(); tick();
      end

      // Random traffic against the model.
      gnt_seen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         adv();
         rst = ($urandom_range(0, 499) != 0);
         bus.vga_req  = 1'($urandom_range(0, 1));
         bus.vga_addr = 13'($urandom_range(0, 63));
         bus.cpu_req  = ($urandom_range(0, 2) != 0);
         bus.cpu_we   = 1'($urandom_range(0, 1));
         base         = ($urandom_range(0, 1) != 0) ? 16'hC000 : 16'h0000;
         bus.cpu_addr = base | 16'($urandom_range(0, 63));
         bus.cpu_dbw  = 8'($urandom);
         if (!bus.dma_req || gnt_seen) begin
            bus.dma_req  = 1'($urandom_range(0, 1));
            bus.dma_we   = 1'($urandom_range(0, 1));
            base         = ($urandom_range(0, 1) != 0) ? 16'hC000 : 16'h0000;
            bus.dma_addr = base | 16'($urandom_range(0, 63));
            bus.dma_dbw  = 8'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            bus.dma_req = 1'b0;
         end
         tick();
         gnt_seen = bus.dma_gnt;
      end
      adv();
      rst = 1'b1;
      idle_inputs();
      repeat (4) begin tick(); adv(); end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
